// File: rtl/scroll_controller.sv
// +----------------------------------------------------------------------------+
// | scroll_controller                                                          |
// | Advances the rotating-message base index and multiplexes the four digits.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module scroll_controller #(
  parameter int CNT_W   = 23,
  parameter int MSG_LEN = 16,
  parameter int IDX_W   = 4,
  parameter int REF_HI  = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] time_counter,
  input  logic             auto_en,
  input  logic             step,
  input  logic             dir,
  output logic [IDX_W-1:0] base_idx,
  output logic             rotate_pulse,
  output logic [3:0]       an,
  output logic [IDX_W-1:0] char_addr
);

  localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(MSG_LEN - 1);
  localparam logic [IDX_W-1:0] C_ONE     = IDX_W'(1);
  localparam logic [IDX_W:0]   C_LEN     = (IDX_W+1)'(MSG_LEN);
  localparam logic [IDX_W-1:0] C_LEN_LO  = IDX_W'(MSG_LEN);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_msb_q;
  logic             r_step_q;

  logic             w_wrap;
  logic             w_step_ev;
  logic             w_advance;
  logic [1:0]       w_digit;
  logic [IDX_W-1:0] w_next_base;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_char;
  logic             w_unused_tc;

  assign w_wrap    = r_msb_q & ~time_counter[CNT_W-1];
  assign w_step_ev = step & ~r_step_q;
  assign w_advance = (r_state == ST_RUN) ? w_wrap : w_step_ev;
  assign w_digit   = time_counter[REF_HI -: 2];

  // Only the MSB and the refresh slice of the counter are consumed.
  assign w_unused_tc = &{1'b0, time_counter};

  always_comb begin
    w_next_base = base_idx;
    if (dir) begin
      w_next_base = (base_idx == '0) ? C_LAST : base_idx - C_ONE;
    end else begin
      w_next_base = (base_idx == C_LAST) ? '0 : base_idx + C_ONE;
    end
  end

  // base_idx < MSG_LEN and digit <= 3 <= MSG_LEN-1, so one subtract is enough;
  // the low bits wrap correctly even when MSG_LEN == 2**IDX_W.
  assign w_sum  = {1'b0, base_idx} + {{(IDX_W-1){1'b0}}, w_digit};
  assign w_char = (w_sum >= C_LEN) ? (w_sum[IDX_W-1:0] - C_LEN_LO) : w_sum[IDX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_msb_q      <= 1'b0;
      r_step_q     <= 1'b0;
      base_idx     <= '0;
      rotate_pulse <= 1'b0;
      an           <= 4'b1111;
      char_addr    <= '0;
    end else begin
      r_msb_q      <= time_counter[CNT_W-1];
      r_step_q     <= step;
      rotate_pulse <= w_advance;
      if (w_advance) begin
        base_idx <= w_next_base;
      end
      case (r_state)
        ST_IDLE: if (auto_en)  r_state <= ST_RUN;
        ST_RUN:  if (!auto_en) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      an        <= ~(4'b1000 >> w_digit);
      char_addr <= w_char;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scroll_controller.sv
// +----------------------------------------------------------------------------+
// | tb_scroll_controller                                                       |
// | Self-checking bench: vector table, directed corner cases, random vs model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_scroll_controller;

  localparam int CNT_W = 6;
  localparam int MSG   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] time_counter = '0;
  logic             auto_en = 1'b0;
  logic             step = 1'b0;
  logic             dir = 1'b0;
  logic [3:0]       base_idx;
  logic             rotate_pulse;
  logic [3:0]       an;
  logic [3:0]       char_addr;

  scroll_controller #(
    .CNT_W(CNT_W), .MSG_LEN(MSG), .IDX_W(4), .REF_HI(2)
  ) dut (
    .clk(clk), .reset(reset), .time_counter(time_counter), .auto_en(auto_en),
    .step(step), .dir(dir), .base_idx(base_idx), .rotate_pulse(rotate_pulse),
    .an(an), .char_addr(char_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_pulse = 0;
  logic [CNT_W-1:0] tcnt = '0;

  // Reference model state: mode, base and the previously sampled inputs.
  bit m_run;
  int m_base, m_pulse, m_an, m_char;
  bit m_msb, m_stepq;

  typedef struct {
    logic [CNT_W-1:0] tc;
    logic a, s, d;
    int base, pulse, anv, chr;
  } vec_t;
  vec_t tbl[17];

  function automatic vec_t mk(int tc, bit a, bit s, bit d, int b, int p, int anv, int c);
    vec_t v;
    v.tc = CNT_W'(tc); v.a = a; v.s = s; v.d = d;
    v.base = b; v.pulse = p; v.anv = anv; v.chr = c;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_base = 0; m_pulse = 0; m_an = 15; m_char = 0;
    m_msb = 0; m_stepq = 0;
  endtask

  task automatic model_edge(input logic [CNT_W-1:0] tc, input bit a, input bit s, input bit d);
    int dg;
    bit adv;
    dg = int'(tc[2:1]);
    adv = m_run ? (m_msb && !tc[CNT_W-1]) : (s && !m_stepq);
    m_an = 15 & ~(1 << (3 - dg));
    m_char = (m_base + dg) % MSG;
    m_pulse = adv ? 1 : 0;
    if (adv) m_base = d ? (m_base + MSG - 1) % MSG : (m_base + 1) % MSG;
    m_run = a; m_msb = tc[CNT_W-1]; m_stepq = s;
  endtask

  task automatic tick(input logic [CNT_W-1:0] tc, input bit a, input bit s, input bit d);
    @(negedge clk);
    time_counter = tc; auto_en = a; step = s; dir = d;
    @(posedge clk);
    model_edge(tc, a, s, d);
    #1;
    if (rotate_pulse) n_pulse++;
    chk("model_base", int'(base_idx), m_base);
    chk("model_pulse", int'(rotate_pulse), m_pulse);
    chk("model_an", int'(an), m_an);
    chk("model_char", int'(char_addr), m_char);
  endtask

  task automatic count_ticks(input int n, input bit a, input bit d);
    for (int i = 0; i < n; i++) begin
      tick(tcnt, a, 1'b0, d);
      tcnt = tcnt + 1'b1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_base"}, int'(base_idx), 0);
    chk({tag, "_pulse"}, int'(rotate_pulse), 0);
    chk({tag, "_an"}, int'(an), 15);
    chk({tag, "_char"}, int'(char_addr), 0);
  endtask

  // Asynchronous assert mid-cycle, hold across an edge, release with tc_rel applied.
  task automatic apply_reset(input logic [CNT_W-1:0] tc_rel);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_async");
    @(posedge clk);
    #1 chk_reset_vals("rst_held");
    @(negedge clk);
    time_counter = tc_rel;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    tbl[0]  = mk(0, 0, 0, 1,  0, 0, 4'b0111,  0);
    tbl[1]  = mk(0, 0, 1, 1, 15, 1, 4'b0111,  0);
    tbl[2]  = mk(0, 0, 1, 1, 15, 0, 4'b0111, 15);
    tbl[3]  = mk(0, 0, 1, 1, 15, 0, 4'b0111, 15);
    tbl[4]  = mk(0, 0, 1, 1, 15, 0, 4'b0111, 15);
    tbl[5]  = mk(0, 0, 1, 1, 15, 0, 4'b0111, 15);
    tbl[6]  = mk(0, 0, 0, 1, 15, 0, 4'b0111, 15);
    tbl[7]  = mk(0, 0, 1, 1, 14, 1, 4'b0111, 15);
    tbl[8]  = mk(0, 0, 0, 1, 14, 0, 4'b0111, 14);
    tbl[9]  = mk(0, 0, 0, 1, 14, 0, 4'b0111, 14);
    tbl[10] = mk(2, 0, 0, 1, 14, 0, 4'b1011, 15);
    tbl[11] = mk(4, 0, 0, 1, 14, 0, 4'b1101,  0);
    tbl[12] = mk(6, 0, 0, 1, 14, 0, 4'b1110,  1);
    tbl[13] = mk(6, 0, 1, 0, 15, 1, 4'b1110,  1);
    tbl[14] = mk(6, 0, 0, 0, 15, 0, 4'b1110,  2);
    tbl[15] = mk(6, 0, 1, 0,  0, 1, 4'b1110,  2);
    tbl[16] = mk(0, 0, 0, 0,  0, 0, 4'b0111,  0);

    // Reset and idle: power-on reset, count, reset mid-count, three wraps ignored.
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    count_ticks(20, 1'b0, 1'b0);
    apply_reset(tcnt);
    p0 = n_pulse;
    count_ticks(3 * 64 + 1, 1'b0, 1'b0);
    chk("idle_base", int'(base_idx), 0);
    chk("idle_pulses", n_pulse - p0, 0);

    // Auto rotate left over 17 wraps.
    p0 = n_pulse;
    count_ticks(17 * 64, 1'b1, 1'b0);
    chk("auto_base", int'(base_idx), 1);
    chk("auto_pulses", n_pulse - p0, 17);

    // Held-button manual steps and digit-mux wrap-around from the table.
    apply_reset(6'd0);
    p0 = n_pulse;
    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].tc, tbl[i].a, tbl[i].s, tbl[i].d);
      chk($sformatf("vec%0d_base", i), int'(base_idx), tbl[i].base);
      chk($sformatf("vec%0d_pulse", i), int'(rotate_pulse), tbl[i].pulse);
      chk($sformatf("vec%0d_an", i), int'(an), tbl[i].anv);
      chk($sformatf("vec%0d_char", i), int'(char_addr), tbl[i].chr);
      if (i == 8) chk("manual_pulses", n_pulse - p0, 2);
    end

    // Mode interaction: step ignored in RUN, wrap coinciding with auto_en falling.
    tick(6'd8, 1, 0, 0);
    tick(6'd10, 1, 1, 0);
    tick(6'd12, 1, 0, 0);
    chk("run_step_ignored", int'(base_idx), 0);
    p0 = n_pulse;
    tick(6'd40, 1, 0, 0);
    tick(6'd63, 1, 0, 0);
    tick(6'd0, 0, 0, 0);
    tick(6'd40, 0, 0, 0);
    tick(6'd0, 0, 0, 0);
    tick(6'd40, 0, 0, 0);
    tick(6'd0, 0, 0, 0);
    chk("drop_auto_base", int'(base_idx), 1);
    chk("drop_auto_pulses", n_pulse - p0, 1);
    tick(6'd20, 1, 1, 0);
    tick(6'd22, 1, 0, 0);
    chk("step_and_rise", int'(base_idx), 2);
    tick(6'd40, 1, 0, 0);
    tick(6'd0, 1, 0, 0);
    chk("now_running", int'(base_idx), 3);

    // Reset mid-operation with MSB high and base 7; release with MSB low.
    for (int i = 0; i < 4; i++) begin
      tick(6'd40, 1, 0, 0);
      tick(6'd0, 1, 0, 0);
    end
    tick(6'd40, 1, 0, 0);
    chk("pre_reset_base", int'(base_idx), 7);
    apply_reset(6'd0);
    p0 = n_pulse;
    tick(6'd0, 1, 0, 0);
    tick(6'd4, 1, 0, 0);
    chk("post_reset_base", int'(base_idx), 0);
    chk("post_reset_pulses", n_pulse - p0, 0);
    tick(6'd40, 1, 0, 0);
    tick(6'd0, 1, 0, 0);
    chk("post_reset_wrap", int'(base_idx), 1);

    // Randomized traffic against the model.
    begin
      bit a, s, d;
      a = 1; s = 0; d = 0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 49) == 0) a = ~a;
        if ($urandom_range(0, 99) == 0) d = ~d;
        s = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 15) == 0) tcnt = CNT_W'($urandom_range(0, 63));
        else tcnt = tcnt + 1'b1;
        tick(tcnt, a, s, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
